// File: rtl/strassen_pkg.sv
// strassen_pkg: types and constants shared by the Strassen 2x2 sequencer.
//   state_e      : controller states (IDLE, MULT, DONE)
//   NUM_PRODUCTS : number of Strassen products (M1..M7)
//   LAST_IDX     : product index of M7, the final MULT cycle
//   sign_table() : contribution sign of product k to C11, C12, C21, C22
package strassen_pkg;

   typedef enum logic [1:0] {IDLE, MULT, DONE} state_e;

   localparam int         NUM_PRODUCTS = 7;
   localparam logic [2:0] LAST_IDX     = 3'd6;

   typedef logic signed [1:0] sign_t;

   typedef struct packed {
      sign_t c11;
      sign_t c12;
      sign_t c21;
      sign_t c22;
   } sign_vec_t;

   // +1 adds the product, -1 subtracts it, 0 leaves the element untouched.
   function automatic sign_vec_t sign_table(input logic [2:0] k);
      sign_vec_t s;
      s = '0;
      case (k)
         3'd0: s = '{c11:  2'sd1, c12:  2'sd0, c21:  2'sd0, c22:  2'sd1};
         3'd1: s = '{c11:  2'sd0, c12:  2'sd0, c21:  2'sd1, c22: -2'sd1};
         3'd2: s = '{c11:  2'sd0, c12:  2'sd1, c21:  2'sd0, c22:  2'sd1};
         3'd3: s = '{c11:  2'sd1, c12:  2'sd0, c21:  2'sd1, c22:  2'sd0};
         3'd4: s = '{c11: -2'sd1, c12:  2'sd1, c21:  2'sd0, c22:  2'sd0};
         3'd5: s = '{c11:  2'sd0, c12:  2'sd0, c21:  2'sd0, c22:  2'sd1};
         3'd6: s = '{c11:  2'sd1, c12:  2'sd0, c21:  2'sd0, c22:  2'sd0};
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/strassen_term_sel.sv
// strassen_term_sel: combinational operand selector for the shared multiplier.
//   k_i            : product index 0..6 (M1..M7)
//   a11_i..b22_i   : registered signed operands, WIDTH bits
//   op_a_o, op_b_o : signed WIDTH+1 multiplier operands for product k
module strassen_term_sel
   import strassen_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [2:0]              k_i,
   input  logic signed [WIDTH-1:0] a11_i,
   input  logic signed [WIDTH-1:0] a12_i,
   input  logic signed [WIDTH-1:0] a21_i,
   input  logic signed [WIDTH-1:0] a22_i,
   input  logic signed [WIDTH-1:0] b11_i,
   input  logic signed [WIDTH-1:0] b12_i,
   input  logic signed [WIDTH-1:0] b21_i,
   input  logic signed [WIDTH-1:0] b22_i,
   output logic signed [WIDTH:0]   op_a_o,
   output logic signed [WIDTH:0]   op_b_o
);

   // One extra bit so sums/differences of two elements never overflow.
   logic signed [WIDTH:0] a11_x, a12_x, a21_x, a22_x;
   logic signed [WIDTH:0] b11_x, b12_x, b21_x, b22_x;

   assign a11_x = {a11_i[WIDTH-1], a11_i};
   assign a12_x = {a12_i[WIDTH-1], a12_i};
   assign a21_x = {a21_i[WIDTH-1], a21_i};
   assign a22_x = {a22_i[WIDTH-1], a22_i};
   assign b11_x = {b11_i[WIDTH-1], b11_i};
   assign b12_x = {b12_i[WIDTH-1], b12_i};
   assign b21_x = {b21_i[WIDTH-1], b21_i};
   assign b22_x = {b22_i[WIDTH-1], b22_i};

   always_comb begin
      // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
      op_a_o = '0;
      op_b_o = '0;
      case (k_i)
         3'd0: begin op_a_o = a11_x + a22_x; op_b_o = b11_x + b22_x; end
         3'd1: begin op_a_o = a21_x + a22_x; op_b_o = b11_x;         end
         3'd2: begin op_a_o = a11_x;         op_b_o = b12_x - b22_x; end
         3'd3: begin op_a_o = a22_x;         op_b_o = b21_x - b11_x; end
         3'd4: begin op_a_o = a11_x + a12_x; op_b_o = b22_x;         end
         3'd5: begin op_a_o = a21_x - a11_x; op_b_o = b11_x + b12_x; end
         3'd6: begin op_a_o = a12_x - a22_x; op_b_o = b21_x + b22_x; end
         default: ;
      endcase
   end

endmodule

// File: rtl/strassen_seq.sv
// strassen_seq: 2x2 signed matrix multiply using Strassen's seven products
// issued one per cycle on a single shared multiplier.
//   clk, reset              : rising-edge clock, async active-high reset
//   in_valid / in_ready     : operand handshake (in_ready high only in IDLE)
//   a11..a22, b11..b22      : signed WIDTH-bit operands, captured on accept
//   out_valid / out_ready   : result handshake (out_valid high only in DONE)
//   c11..c22                : signed OUT_W-bit results, modulo 2^OUT_W
//   busy, prod_idx          : MULT indicator and index of the product in flight
module strassen_seq
   import strassen_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OUT_W = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] a11,
   input  logic signed [WIDTH-1:0] a12,
   input  logic signed [WIDTH-1:0] a21,
   input  logic signed [WIDTH-1:0] a22,
   input  logic signed [WIDTH-1:0] b11,
   input  logic signed [WIDTH-1:0] b12,
   input  logic signed [WIDTH-1:0] b21,
   input  logic signed [WIDTH-1:0] b22,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] c11,
   output logic signed [OUT_W-1:0] c12,
   output logic signed [OUT_W-1:0] c21,
   output logic signed [OUT_W-1:0] c22,
   output logic                    busy,
   output logic [2:0]              prod_idx
);

   localparam int PROD_W = 2 * WIDTH + 2;

   state_e                  state_q;
   logic [2:0]              k_q;
   logic                    busy_q, out_valid_q;
   logic signed [WIDTH-1:0] a11_q, a12_q, a21_q, a22_q;
   logic signed [WIDTH-1:0] b11_q, b12_q, b21_q, b22_q;
   logic signed [OUT_W-1:0] c11_q, c12_q, c21_q, c22_q;
   logic signed [OUT_W-1:0] c11_d, c12_d, c21_d, c22_d;

   logic signed [WIDTH:0]    op_a, op_b;
   logic signed [PROD_W-1:0] op_a_w, op_b_w, prod;
   logic signed [OUT_W-1:0]  prod_ext;
   sign_vec_t                sgn;

   strassen_term_sel #(.WIDTH(WIDTH)) u_term_sel (
      .k_i   (k_q),
      .a11_i (a11_q), .a12_i (a12_q), .a21_i (a21_q), .a22_i (a22_q),
      .b11_i (b11_q), .b12_i (b12_q), .b21_i (b21_q), .b22_i (b22_q),
      .op_a_o(op_a),
      .op_b_o(op_b)
   );

   // Widen before multiplying so the full 2*WIDTH+2 product is kept.
   assign op_a_w = {{(PROD_W-WIDTH-1){op_a[WIDTH]}}, op_a};
   assign op_b_w = {{(PROD_W-WIDTH-1){op_b[WIDTH]}}, op_b};
   assign prod   = op_a_w * op_b_w;

   generate
      if (OUT_W > PROD_W) begin : g_sext
         assign prod_ext = {{(OUT_W-PROD_W){prod[PROD_W-1]}}, prod};
      end else if (OUT_W == PROD_W) begin : g_same
         assign prod_ext = prod;
      end else begin : g_trunc
         // Truncation is safe: the final result is only defined modulo 2^OUT_W.
         assign prod_ext = prod[OUT_W-1:0];
      end
   endgenerate

   function automatic logic signed [OUT_W-1:0] contrib(
      input sign_t                   s,
      input logic signed [OUT_W-1:0] p
   );
      case (s)
         2'b01:   return p;
         2'b11:   return -p;
         default: return '0;
      endcase
   endfunction

   always_comb begin
      sgn   = sign_table(k_q);
      c11_d = c11_q + contrib(sgn.c11, prod_ext);
      c12_d = c12_q + contrib(sgn.c12, prod_ext);
      c21_d = c21_q + contrib(sgn.c21, prod_ext);
      c22_d = c22_q + contrib(sgn.c22, prod_ext);
   end

   // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         busy_q      <= 1'b0;
         out_valid_q <= 1'b0;
         // NOTE: operand registers are reset too; they are few and the block clears all state.
         a11_q <= '0; a12_q <= '0; a21_q <= '0; a22_q <= '0;
         b11_q <= '0; b12_q <= '0; b21_q <= '0; b22_q <= '0;
         c11_q <= '0; c12_q <= '0; c21_q <= '0; c22_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  a11_q <= a11; a12_q <= a12; a21_q <= a21; a22_q <= a22;
                  b11_q <= b11; b12_q <= b12; b21_q <= b21; b22_q <= b22;
                  c11_q <= '0;  c12_q <= '0;  c21_q <= '0;  c22_q <= '0;
                  k_q     <= '0;
                  busy_q  <= 1'b1;
                  state_q <= MULT;
               end
            end
            MULT: begin
               c11_q <= c11_d;
               c12_q <= c12_d;
               c21_q <= c21_d;
               c22_q <= c22_d;
               if (k_q == LAST_IDX) begin
                  k_q         <= '0;
                  busy_q      <= 1'b0;
                  out_valid_q <= 1'b1;
                  state_q     <= DONE;
               end else begin
                  k_q <= k_q + 3'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign prod_idx  = k_q;
   assign c11       = c11_q;
   assign c12       = c12_q;
   assign c21       = c21_q;
   assign c22       = c22_q;

endmodule

// File: tb/tb_strassen_seq.sv
// tb_strassen_seq: table-driven bench for strassen_seq, plus hand-written
// back-pressure and mid-MULT reset sequences.
module tb_strassen_seq;

   logic               clk, reset;
   logic               in_valid, in_ready, out_valid, out_ready, busy;
   logic signed [15:0] a11, a12, a21, a22, b11, b12, b21, b22;
   logic signed [31:0] c11, c12, c21, c22;
   logic [2:0]         prod_idx;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [3:0][15:0] a;   // [0]=x11 [1]=x12 [2]=x21 [3]=x22
      logic [3:0][15:0] b;
      logic [3:0][31:0] c;
   } vec_t;

   vec_t vecs [6];

   strassen_seq #(.WIDTH(16), .OUT_W(32)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .a11(a11), .a12(a12), .a21(a21), .a22(a22),
      .b11(b11), .b12(b12), .b21(b21), .b22(b22),
      .out_valid(out_valid), .out_ready(out_ready),
      .c11(c11), .c12(c12), .c21(c21), .c22(c22),
      .busy(busy), .prod_idx(prod_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic signed [63:0] act,
                        input logic signed [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic vec_t mk(input int a11_v, a12_v, a21_v, a22_v,
                               input int b11_v, b12_v, b21_v, b22_v,
                               input int c11_v, c12_v, c21_v, c22_v);
      vec_t v;
      v.a[0] = 16'(a11_v); v.a[1] = 16'(a12_v); v.a[2] = 16'(a21_v); v.a[3] = 16'(a22_v);
      v.b[0] = 16'(b11_v); v.b[1] = 16'(b12_v); v.b[2] = 16'(b21_v); v.b[3] = 16'(b22_v);
      v.c[0] = 32'(c11_v); v.c[1] = 32'(c12_v); v.c[2] = 32'(c21_v); v.c[3] = 32'(c22_v);
      return v;
   endfunction

   task automatic check_c(input string tag, input vec_t v);
      check({tag, " c11"}, c11, $signed(v.c[0]));
      check({tag, " c12"}, c12, $signed(v.c[1]));
      check({tag, " c21"}, c21, $signed(v.c[2]));
      check({tag, " c22"}, c22, $signed(v.c[3]));
   endtask

   task automatic drive_ops(input vec_t v);
      a11 = v.a[0]; a12 = v.a[1]; a21 = v.a[2]; a22 = v.a[3];
      b11 = v.b[0]; b12 = v.b[1]; b21 = v.b[2]; b22 = v.b[3];
   endtask

   task automatic scramble_ops();
      a11 = 16'($urandom); a12 = 16'($urandom); a21 = 16'($urandom); a22 = 16'($urandom);
      b11 = 16'($urandom); b12 = 16'($urandom); b21 = 16'($urandom); b22 = 16'($urandom);
   endtask

   // One full transaction on a fixed cycle schedule; operands are scrambled and
   // in_valid left high during MULT/DONE, both of which must be ignored.
   task automatic run_txn(input vec_t v, input int hold, input string tag);
      @(negedge clk);
      check({tag, " in_ready idle"}, in_ready, 1);
      drive_ops(v);
      in_valid  = 1'b1;
      out_ready = (hold == 0);
      @(negedge clk);
      for (int k = 0; k < 7; k++) begin
         check($sformatf("%s busy k%0d", tag, k), busy, 1);
         check($sformatf("%s prod_idx k%0d", tag, k), prod_idx, k);
         check($sformatf("%s out_valid k%0d", tag, k), out_valid, 0);
         scramble_ops();
         @(negedge clk);
      end
      check({tag, " out_valid done"}, out_valid, 1);
      check({tag, " in_ready done"}, in_ready, 0);
      check({tag, " busy done"}, busy, 0);
      check_c(tag, v);
      for (int h = 0; h < hold; h++) begin
         @(negedge clk);
         check($sformatf("%s held out_valid h%0d", tag, h), out_valid, 1);
         check($sformatf("%s held in_ready h%0d", tag, h), in_ready, 0);
         check_c($sformatf("%s held h%0d", tag, h), v);
      end
      out_ready = 1'b1;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check({tag, " out_valid after"}, out_valid, 0);
      check({tag, " in_ready after"}, in_ready, 1);
   endtask

   initial begin
      vecs[0] = mk(0, 1, 2, 3,   4, 5, 6, 7,   6, 7, 26, 31);
      vecs[1] = mk(-3, 2, 5, -1,   4, -6, -2, 7,   -16, 32, 22, -37);
      vecs[2] = mk(1, 0, 0, 1,   4, 5, 6, 7,   4, 5, 6, 7);
      vecs[3] = mk(32767, 32767, 32767, 32767,   32767, 32767, 32767, 32767,
                   2147352578, 2147352578, 2147352578, 2147352578);
      vecs[4] = mk(-32768, -32768, -32768, -32768,   -32768, -32768, -32768, -32768,
                   32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000, 32'sh8000_0000);
      vecs[5] = mk(-32768, 32767, 1, -1,   2, -1, -32768, 0,
                   -1073774592, 32768, 32770, -1);

      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      drive_ops(vecs[0]);
      #12;
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset busy", busy, 0);
      check("reset prod_idx", prod_idx, 0);
      check("reset c11", c11, 0);
      check("reset c22", c22, 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 6; i++) run_txn(vecs[i], 0, $sformatf("v%0d", i));

      run_txn(vecs[1], 5, "backpressure");

      // Reset while product k=3 is in flight: partial result must be dropped.
      @(negedge clk);
      drive_ops(vecs[0]);
      in_valid = 1'b1;
      for (int k = 0; k < 4; k++) @(negedge clk);
      in_valid = 1'b0;
      check("midreset prod_idx before", prod_idx, 3);
      check("midreset c11 partial", c11, 33);
      #1 reset = 1'b1;
      #1;
      check("midreset out_valid", out_valid, 0);
      check("midreset busy", busy, 0);
      check("midreset prod_idx", prod_idx, 0);
      check("midreset in_ready", in_ready, 1);
      check("midreset c11", c11, 0);
      check("midreset c12", c12, 0);
      check("midreset c21", c21, 0);
      check("midreset c22", c22, 0);
      @(negedge clk);
      reset = 1'b0;
      run_txn(vecs[2], 0, "after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
